// File: rtl/complement_base_master.sv
// rtl/complement_base_master.sv - Avalon-MM initiator that writes one base to the s0 slave and streams back its complement
module complement_base_master #(
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   csi_clock,
  input  logic                   rsi_reset_n,
  input  logic [0:DATA_WIDTH-1]  asi_in_data,
  input  logic                   asi_in_valid,
  output logic                   asi_in_ready,
  output logic                   avm_m0_write,
  output logic [0:DATA_WIDTH-1]  avm_m0_writedata,
  output logic                   avm_m0_read,
  input  logic [0:DATA_WIDTH-1]  avm_m0_readdata,
  input  logic                   avm_m0_waitrequest,
  output logic [0:DATA_WIDTH-1]  aso_out_data,
  output logic                   aso_out_valid,
  input  logic                   aso_out_ready,
  output logic [COUNT_WIDTH-1:0] coe_count,
  output logic                   coe_busy
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_LAT, S_OUT} state_t;

  // LAT holds for READ_LATENCY cycles, so the counter starts one below it
  localparam logic [2:0] LAT_LOAD = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

  state_t                  state_q, state_d;
  logic [0:DATA_WIDTH-1]   base_q, base_d;
  logic [0:DATA_WIDTH-1]   result_q, result_d;
  logic [2:0]              lat_q, lat_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;

  always_ff @(posedge csi_clock) begin
    if (!rsi_reset_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      result_q <= '0;
      lat_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      result_q <= result_d;
      lat_q    <= lat_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    result_d      = result_q;
    lat_d         = lat_q;
    count_d       = count_q;
    avm_m0_write  = 1'b0;
    avm_m0_read   = 1'b0;
    aso_out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (asi_in_valid) begin
          base_d  = asi_in_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        avm_m0_write = 1'b1;
        if (!avm_m0_waitrequest) state_d = S_READ;
      end
      S_READ: begin
        avm_m0_read = 1'b1;
        if (!avm_m0_waitrequest) begin
          if (READ_LATENCY == 0) begin
            result_d = avm_m0_readdata;
            state_d  = S_OUT;
          end else begin
            lat_d   = LAT_LOAD;
            state_d = S_LAT;
          end
        end
      end
      S_LAT: begin
        if (lat_q == 3'd0) begin
          result_d = avm_m0_readdata;
          state_d  = S_OUT;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      S_OUT: begin
        aso_out_valid = 1'b1;
        if (aso_out_ready) begin
          count_d = count_q + COUNT_WIDTH'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ready is gated by reset so nothing is offered while reset is held
  assign asi_in_ready     = (state_q == S_IDLE) && rsi_reset_n;
  assign avm_m0_writedata = base_q;
  assign aso_out_data     = result_q;
  assign coe_count        = count_q;
  assign coe_busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_complement_base_master.sv
// tb/tb_complement_base_master.sv - self-checking bench for complement_base_master (READ_LATENCY 0 and 3)
module tb_complement_base_master;

  localparam int RL0 = 0;
  localparam int RL1 = 3;

  logic       clk;
  logic       rst_n    [2];
  logic [7:0] in_data  [2];
  logic       in_valid [2];
  logic       in_ready [2];
  logic       wr       [2];
  logic [7:0] wdata    [2];
  logic       rd       [2];
  logic [7:0] rdata    [2];
  logic       waitreq  [2];
  logic [7:0] out_data [2];
  logic       out_valid[2];
  logic       out_ready[2];
  logic       busy     [2];
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  logic [7:0]  stored [2];
  int unsigned pend   [2];
  logic [7:0]  junk   [2];

  int checks = 0;
  int errors = 0;
  int exp_cnt[2];

  complement_base_master #(.DATA_WIDTH(8), .READ_LATENCY(RL0), .COUNT_WIDTH(16)) u_dut0 (
    .csi_clock(clk), .rsi_reset_n(rst_n[0]),
    .asi_in_data(in_data[0]), .asi_in_valid(in_valid[0]), .asi_in_ready(in_ready[0]),
    .avm_m0_write(wr[0]), .avm_m0_writedata(wdata[0]), .avm_m0_read(rd[0]),
    .avm_m0_readdata(rdata[0]), .avm_m0_waitrequest(waitreq[0]),
    .aso_out_data(out_data[0]), .aso_out_valid(out_valid[0]), .aso_out_ready(out_ready[0]),
    .coe_count(cnt0), .coe_busy(busy[0])
  );

  complement_base_master #(.DATA_WIDTH(8), .READ_LATENCY(RL1), .COUNT_WIDTH(2)) u_dut1 (
    .csi_clock(clk), .rsi_reset_n(rst_n[1]),
    .asi_in_data(in_data[1]), .asi_in_valid(in_valid[1]), .asi_in_ready(in_ready[1]),
    .avm_m0_write(wr[1]), .avm_m0_writedata(wdata[1]), .avm_m0_read(rd[1]),
    .avm_m0_readdata(rdata[1]), .avm_m0_waitrequest(waitreq[1]),
    .aso_out_data(out_data[1]), .aso_out_valid(out_valid[1]), .aso_out_ready(out_ready[1]),
    .coe_count(cnt1), .coe_busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] comp(input logic [7:0] b);
    case (b)
      8'h41:   comp = 8'h54;
      8'h54:   comp = 8'h41;
      8'h43:   comp = 8'h47;
      8'h47:   comp = 8'h43;
      default: comp = ~b;
    endcase
  endfunction

  function automatic int rl_of(input int d);
    rl_of = (d == 0) ? RL0 : RL1;
  endfunction

  function automatic int cnt_mask(input int d);
    cnt_mask = (d == 0) ? 16'hFFFF : 2'h3;
  endfunction

  function automatic int cnt_of(input int d);
    cnt_of = (d == 0) ? int'(cnt0) : int'(cnt1);
  endfunction

  // Slave model: the true complement appears only in the capture cycle, corrupted data elsewhere
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      junk[d] <= 8'($urandom_range(1, 255));
      if (!rst_n[d]) begin
        pend[d] <= 0;
      end else begin
        if (wr[d] && !waitreq[d]) stored[d] <= wdata[d];
        if (rd[d] && !waitreq[d]) pend[d] <= rl_of(d);
        else if (pend[d] != 0)    pend[d] <= pend[d] - 1;
      end
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      rdata[d] = comp(stored[d]) ^ junk[d];
      if ((rl_of(d) == 0 && rd[d] && !waitreq[d]) || (rl_of(d) > 0 && pend[d] == 1))
        rdata[d] = comp(stored[d]);
    end
  end

  // Entered at a negedge with the DUT idle; returns at the negedge of the following idle cycle
  task automatic send_base(input int d, input logic [7:0] b, input int wst, input int rdst,
                           input int ost, input bit early, input logic [7:0] eb);
    in_valid[d] = 1'b1;
    in_data[d]  = b;
    checks++;
    if (in_ready[d] !== 1'b1) begin
      errors++; $display("FAIL accept_ready dut%0d got %b want 1", d, in_ready[d]);
    end
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_data[d]  = 8'($urandom);
    for (int i = 0; i <= wst; i++) begin
      if (i > 0) @(negedge clk);
      waitreq[d] = (i < wst);
      checks++;
      if (wr[d] !== 1'b1 || wdata[d] !== b || rd[d] !== 1'b0 || in_ready[d] !== 1'b0 ||
          out_valid[d] !== 1'b0 || busy[d] !== 1'b1) begin
        errors++;
        $display("FAIL write_phase dut%0d cyc%0d wr=%b wdata=%h rd=%b rdy=%b ov=%b busy=%b want 1 %h 0 0 0 1",
                 d, i, wr[d], wdata[d], rd[d], in_ready[d], out_valid[d], busy[d], b);
      end
    end
    for (int i = 0; i <= rdst; i++) begin
      @(negedge clk);
      waitreq[d] = (i < rdst);
      checks++;
      if (rd[d] !== 1'b1 || wr[d] !== 1'b0 || in_ready[d] !== 1'b0 || out_valid[d] !== 1'b0) begin
        errors++;
        $display("FAIL read_phase dut%0d cyc%0d rd=%b wr=%b rdy=%b ov=%b want 1 0 0 0",
                 d, i, rd[d], wr[d], in_ready[d], out_valid[d]);
      end
    end
    for (int i = 0; i < rl_of(d); i++) begin
      @(negedge clk);
      waitreq[d] = 1'($urandom);
      checks++;
      if (rd[d] !== 1'b0 || wr[d] !== 1'b0 || out_valid[d] !== 1'b0 || in_ready[d] !== 1'b0) begin
        errors++;
        $display("FAIL latency_phase dut%0d cyc%0d rd=%b wr=%b ov=%b rdy=%b want 0 0 0 0",
                 d, i, rd[d], wr[d], out_valid[d], in_ready[d]);
      end
    end
    for (int i = 0; i <= ost; i++) begin
      @(negedge clk);
      waitreq[d]   = 1'($urandom);
      out_ready[d] = (i == ost);
      if (early) begin
        in_valid[d] = 1'b1;
        in_data[d]  = eb;
      end
      checks++;
      if (out_valid[d] !== 1'b1 || out_data[d] !== comp(b) || in_ready[d] !== 1'b0 ||
          wr[d] !== 1'b0 || rd[d] !== 1'b0 || cnt_of(d) != exp_cnt[d]) begin
        errors++;
        $display("FAIL out_phase dut%0d cyc%0d ov=%b data=%h rdy=%b wr=%b rd=%b cnt=%0d want 1 %h 0 0 0 %0d",
                 d, i, out_valid[d], out_data[d], in_ready[d], wr[d], rd[d], cnt_of(d), comp(b), exp_cnt[d]);
      end
    end
    exp_cnt[d] = (exp_cnt[d] + 1) & cnt_mask(d);
    @(negedge clk);
    out_ready[d] = 1'b0;
    in_valid[d]  = early;
    checks++;
    if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || in_ready[d] !== 1'b1 || cnt_of(d) != exp_cnt[d]) begin
      errors++;
      $display("FAIL after_handshake dut%0d ov=%b busy=%b rdy=%b cnt=%0d want 0 0 1 %0d",
               d, out_valid[d], busy[d], in_ready[d], cnt_of(d), exp_cnt[d]);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = 8'h00;
      waitreq[d] = 1'b0; out_ready[d] = 1'b0; exp_cnt[d] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (in_ready[d] !== 1'b0 || wr[d] !== 1'b0 || rd[d] !== 1'b0 || out_valid[d] !== 1'b0 ||
          busy[d] !== 1'b0 || wdata[d] !== 8'h00 || out_data[d] !== 8'h00 || cnt_of(d) != 0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d rdy=%b wr=%b rd=%b ov=%b busy=%b wdata=%h odata=%h cnt=%0d want all 0",
                 d, in_ready[d], wr[d], rd[d], out_valid[d], busy[d], wdata[d], out_data[d], cnt_of(d));
      end
      rst_n[d] = 1'b1;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle dut%0d rdy=%b busy=%b want 1 0", d, in_ready[d], busy[d]);
      end
    end
  endtask

  task automatic test_stream_wrap();
    logic [7:0] seq [4];
    seq = '{8'h41, 8'h43, 8'h47, 8'h54};
    for (int i = 0; i < 4; i++) send_base(1, seq[i], 0, 0, 0, 1'b0, 8'h00);
    checks++;
    if (cnt1 !== 2'd0) begin
      errors++; $display("FAIL count_wrap got %0d want 0", cnt1);
    end
  endtask

  task automatic test_single();
    send_base(0, 8'h41, 0, 0, 0, 1'b0, 8'h00);
    send_base(1, 8'h41, 0, 0, 0, 1'b0, 8'h00);
  endtask

  task automatic test_write_stall();
    send_base(0, 8'h43, 3, 0, 0, 1'b0, 8'h00);
    send_base(1, 8'h43, 3, 2, 0, 1'b0, 8'h00);
  endtask

  task automatic test_backpressure();
    send_base(1, 8'h41, 0, 0, 5, 1'b1, 8'h47);
    send_base(1, 8'h47, 0, 0, 0, 1'b0, 8'h00);
    send_base(0, 8'h54, 1, 1, 5, 1'b1, 8'h43);
    send_base(0, 8'h43, 0, 0, 0, 1'b0, 8'h00);
  endtask

  task automatic test_mid_reset();
    in_valid[1] = 1'b1;
    in_data[1]  = 8'h47;
    repeat (3) begin
      @(negedge clk);
      in_valid[1] = 1'b0;
    end
    rst_n[1] = 1'b0;
    exp_cnt[1] = 0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (wr[1] !== 1'b0 || rd[1] !== 1'b0 || out_valid[1] !== 1'b0 || in_ready[1] !== 1'b0 ||
          busy[1] !== 1'b0 || cnt1 !== 2'd0) begin
        errors++;
        $display("FAIL mid_reset wr=%b rd=%b ov=%b rdy=%b busy=%b cnt=%0d want all 0",
                 wr[1], rd[1], out_valid[1], in_ready[1], busy[1], cnt1);
      end
    end
    rst_n[1] = 1'b1;
    @(negedge clk);
    send_base(1, 8'h54, 0, 0, 0, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    logic [7:0] pool [4];
    logic [7:0] cur, nxt;
    pool = '{8'h41, 8'h43, 8'h47, 8'h54};
    for (int d = 0; d < 2; d++) begin
      cur = pool[$urandom_range(0, 3)];
      for (int n = 0; n < 20; n++) begin
        nxt = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 3)];
        send_base(d, cur, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3),
                  1'($urandom), nxt);
        cur = nxt;
      end
      in_valid[d] = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream_wrap();
    test_single();
    test_write_stall();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
